// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that shares one external memory port between NUM_CH
//   requestors. One transaction is in flight at a time. Writes take two cycles
//   (accept, issue). Reads wait a fixed RD_LATENCY before their data is routed
//   back to the requesting channel.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          synchronous active-high reset
//   ch_req_i         per-channel request, held until ch_gnt_o
//   ch_we_i          per-channel write(1)/read(0), valid with ch_req_i
//   ch_addr_i        packed addresses, channel i at [i*AWIDTH +: AWIDTH]
//   ch_wdata_i       packed write data, channel i at [i*DWIDTH +: DWIDTH]
//   ch_gnt_o         one-hot grant pulse (ISSUE cycle)
//   ch_rvalid_o      one-hot read-data-valid pulse (RESP cycle)
//   ch_rdata_o       shared read data, zero unless ch_rvalid_o is non-zero
//   mem_addr_o       memory address, driven only during ISSUE
//   mem_data_out_o   memory write data, driven only during a write ISSUE
//   mem_data_in_i    memory read data
//   mem_read_en_o    read strobe
//   mem_write_en_o   write strobe
//   busy_o           high whenever the FSM is not IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; latch the winner's request when any ch_req_i is set
// ISSUE  | drive memory strobe, pulse grant, update round-robin pointer
// WAIT   | count down the read latency, capture read data on terminal count
// RESP   | pulse rvalid for the winner and present the captured data

module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int NUM_CH     = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*AWIDTH-1:0] ch_addr_i,
  input  logic [NUM_CH*DWIDTH-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_gnt_o,
  output logic [NUM_CH-1:0]        ch_rvalid_o,
  output logic [DWIDTH-1:0]        ch_rdata_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  output logic [DWIDTH-1:0]        mem_data_out_o,
  input  logic [DWIDTH-1:0]        mem_data_in_i,
  output logic                     mem_read_en_o,
  output logic                     mem_write_en_o,
  output logic                     busy_o
);

  localparam int              IDXW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_CH - 1);
  localparam logic [2:0]      LAT_LOAD = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic [IDXW-1:0]     last_q, last_d;
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [IDXW-1:0]     rr_idx;
  logic                rr_found;
  logic                rr_we;
  logic [AWIDTH-1:0]   rr_addr;
  logic [DWIDTH-1:0]   rr_wdata;

  // Round-robin pick: scan offsets 1..NUM_CH from the last grant so the
  // channel just served has the lowest priority. Constant bit selects only,
  // which keeps the NUM_CH == 1 case a plain fixed grant.
  always_comb begin
    rr_idx   = last_q;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!rr_found && ch_req_i[i] && (i == ((int'(last_q) + k) % NUM_CH))) begin
          rr_idx   = IDXW'(i);
          rr_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_we    = 1'b0;
    rr_addr  = '0;
    rr_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rr_idx == IDXW'(i)) begin
        rr_we    = ch_we_i[i];
        rr_addr  = ch_addr_i[i*AWIDTH +: AWIDTH];
        rr_wdata = ch_wdata_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    last_d         = last_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    cnt_d          = cnt_q;
    ch_gnt_o       = '0;
    ch_rvalid_o    = '0;
    ch_rdata_o     = '0;
    mem_addr_o     = '0;
    mem_data_out_o = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    busy_o         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ch_req_i != '0) begin
          win_d   = rr_idx;
          we_d    = rr_we;
          addr_d  = rr_addr;
          wdata_d = rr_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_addr_o = addr_q;
        ch_gnt_o   = NUM_CH'(1) << win_q;
        last_d     = win_q;
        if (we_q) begin
          mem_write_en_o = 1'b1;
          mem_data_out_o = wdata_q;
          state_d        = S_IDLE;
        end else begin
          mem_read_en_o = 1'b1;
          cnt_d         = LAT_LOAD;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_data_in_i;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        ch_rvalid_o = NUM_CH'(1) << win_q;
        ch_rdata_o  = rdata_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      last_q  <= LAST_RST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
